// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
//
// Iterative BCD-to-binary converter using reverse double dabble. Four BCD
// digits (thousands, hundreds, tens, units) are turned into a W_BIN-bit binary
// word. This is the inverse of the binary-to-BCD shift-add converter. It turns
// operator-entered decimal values back into the binary frequency word.
//
// Each iteration shifts {bcd, bin} right by one bit. It then subtracts 3 from
// every BCD nibble that has reached 8 or more. After W_BIN iterations the
// binary word holds the result and the BCD register has drained to zero.
//
// Optional feature (macro BCD_TO_BIN_FAST_EN):
//   undefined : separate SHIFT and ADJUST states, result after 2*W_BIN cycles
//   defined   : shift and nibble correction merged into one state,
//               result after W_BIN cycles
//
// Handshake (start/done):
//   iStart is sampled only while the block is idle (oBusy low). Valid digits
//   start a conversion, and oBusy rises in the next cycle. When the result is
//   ready, oDone pulses for one cycle with oFrec updated; the block is already
//   idle in that cycle and may accept a new iStart. If any digit is above 9,
//   iStart produces a one-cycle oError pulse instead and the block stays idle.
//   oDone and oError are never high together.
//
// Parameters:
//   W_BIN   width of the binary result; 2**W_BIN must exceed 9999
//
// Ports:
//   iClk     in   1      system clock, rising edge
//   iRst_n   in   1      asynchronous active-low reset
//   iStart   in   1      start request, sampled only in IDLE
//   iUM      in   4      thousands digit
//   iC       in   4      hundreds digit
//   iD       in   4      tens digit
//   iU       in   4      units digit
//   oFrec    out  W_BIN  converted value, held until the next good conversion
//   oDone    out  1      one-cycle pulse, oFrec valid and updated
//   oError   out  1      one-cycle pulse, an input digit was above 9
//   oBusy    out  1      high while a conversion is in progress
//   oState   out  2      current FSM state (debug observation)
// -----------------------------------------------------------------------------
module bcd_to_bin #(
  parameter int W_BIN = 14
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [3:0]       iUM,
  input  logic [3:0]       iC,
  input  logic [3:0]       iD,
  input  logic [3:0]       iU,
  output logic [W_BIN-1:0] oFrec,
  output logic             oDone,
  output logic             oError,
  output logic             oBusy,
  output logic [1:0]       oState
);

  localparam int CW = $clog2(W_BIN + 1);

  // In the fast build S_SHIFT is the single merged iteration state and
  // S_ADJUST is never entered.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_ADJUST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [W_BIN-1:0]  bin_q, bin_d;
  logic [W_BIN-1:0]  frec_q, frec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              digits_bad;
  logic              last_step;
  logic [15:0]       shift_bcd;
  logic [W_BIN-1:0]  shift_bin;

  // A nibble of 8 or more after a right shift means a 1 came down from the
  // next decade. That 1 is worth 5 here rather than 8, so subtract 3.
  function automatic logic [15:0] nibble_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i+3]) begin
        r[4*i +: 4] = b[4*i +: 4] - 4'd3;
      end
    end
    return r;
  endfunction

  assign digits_bad = (iUM > 4'd9) || (iC > 4'd9) || (iD > 4'd9) || (iU > 4'd9);

  // Logical right shift of the concatenation {bcd, bin}.
  assign shift_bcd = {1'b0, bcd_q[15:1]};
  assign shift_bin = {bcd_q[0], bin_q[W_BIN-1:1]};

  // last_step marks the cycle whose register update completes the final
  // iteration. The counter counts shifts already performed.
`ifdef BCD_TO_BIN_FAST_EN
  assign last_step = (state_q == S_SHIFT) && (cnt_q == CW'(W_BIN - 1));
`else
  assign last_step = (state_q == S_ADJUST) && (cnt_q == CW'(W_BIN));
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (iStart && !digits_bad) begin
          state_d = S_SHIFT;
        end
      end
`ifdef BCD_TO_BIN_FAST_EN
      S_SHIFT: begin
        if (last_step) begin
          state_d = S_IDLE;
        end
      end
`else
      S_SHIFT: begin
        state_d = S_ADJUST;
      end
      S_ADJUST: begin
        if (last_step) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SHIFT;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bcd_d  = bcd_q;
    bin_d  = bin_q;
    cnt_d  = cnt_q;
    frec_d = frec_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          if (digits_bad) begin
            err_d = 1'b1;
          end else begin
            bcd_d = {iUM, iC, iD, iU};
            bin_d = '0;
            cnt_d = '0;
          end
        end
      end
`ifdef BCD_TO_BIN_FAST_EN
      S_SHIFT: begin
        bcd_d = nibble_adjust(shift_bcd);
        bin_d = shift_bin;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          frec_d = shift_bin;
          done_d = 1'b1;
        end
      end
`else
      S_SHIFT: begin
        bcd_d = shift_bcd;
        bin_d = shift_bin;
        cnt_d = cnt_q + CW'(1);
      end
      S_ADJUST: begin
        bcd_d = nibble_adjust(bcd_q);
        if (last_step) begin
          frec_d = bin_q;
          done_d = 1'b1;
        end
      end
`endif
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      frec_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      bcd_q  <= bcd_d;
      bin_q  <= bin_d;
      cnt_q  <= cnt_d;
      frec_q <= frec_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign oFrec  = frec_q;
  assign oDone  = done_q;
  assign oError = err_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oState = state_q;

  // Every BCD unit must have moved into the binary word by the last step.
  a_bcd_drained : assert property (
    @(posedge iClk) disable iff (!iRst_n) last_step |-> (bcd_d == 16'd0)
  );

  a_done_err_excl : assert property (
    @(posedge iClk) disable iff (!iRst_n) !(done_q && err_q)
  );

endmodule

// File: tb/tb_bcd_to_bin.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin
//
// Bench for bcd_to_bin. The driver issues conversions and pushes the decimal
// value of the digits, plus the cycle its result must appear, into queues.
// A monitor on the falling edge pops and compares on every oDone or oError.
// It also checks oFrec hold, busy length, single-cycle pulses and missing
// responses.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin;

  localparam int W = 14;
`ifdef BCD_TO_BIN_FAST_EN
  localparam int LAT = W;
`else
  localparam int LAT = 2 * W;
`endif

  logic         iClk = 1'b0;
  logic         iRst_n = 1'b1;
  logic         iStart = 1'b0;
  logic [3:0]   iUM = 4'd0;
  logic [3:0]   iC = 4'd0;
  logic [3:0]   iD = 4'd0;
  logic [3:0]   iU = 4'd0;
  logic [W-1:0] oFrec;
  logic         oDone;
  logic         oError;
  logic         oBusy;
  logic [1:0]   oState;

  bcd_to_bin #(.W_BIN(W)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iStart (iStart),
    .iUM    (iUM),
    .iC     (iC),
    .iD     (iD),
    .iU     (iU),
    .oFrec  (oFrec),
    .oDone  (oDone),
    .oError (oError),
    .oBusy  (oBusy),
    .oState (oState)
  );

  // ---------------------------------------------------------------------------
  // Clock, cycle counter
  // ---------------------------------------------------------------------------
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           err_cyc_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] hold_frec = '0;
  int           busy_run = 0;
  logic         prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Reference model: the decimal value of the digits.
  function automatic int ref_val(input logic [3:0] um, c, d, u);
    return int'(um) * 1000 + int'(c) * 100 + int'(d) * 10 + int'(u);
  endfunction

  function automatic bit ref_bad(input logic [3:0] um, c, d, u);
    return (um > 4'd9) || (c > 4'd9) || (d > 4'd9) || (u > 4'd9);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge iClk) begin
    if (iRst_n) begin
      if (oDone) begin
        check("done_err_excl", {31'd0, oError}, 32'd0);
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (exp_q.size() == 0) begin
          fail_event("unexpected_done");
        end else begin
          logic [W-1:0] e;
          int           ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("frec_value", 32'(oFrec), 32'(e));
          check("done_latency", cyc, ec);
          hold_frec = e;
        end
      end else begin
        check("frec_hold", 32'(oFrec), 32'(hold_frec));
        if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
          fail_event("done_missing");
          void'(exp_q.pop_front());
          void'(exp_cyc_q.pop_front());
        end
      end

      if (oError) begin
        check("err_busy_low", {31'd0, oBusy}, 32'd0);
        if (err_cyc_q.size() == 0) begin
          fail_event("unexpected_error");
        end else begin
          check("err_cycle", cyc, err_cyc_q.pop_front());
        end
      end else if (err_cyc_q.size() > 0 && cyc >= err_cyc_q[0]) begin
        fail_event("error_missing");
        void'(err_cyc_q.pop_front());
      end

      if (oBusy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        check("busy_length", busy_run, LAT);
        busy_run = 0;
      end
      prev_done = oDone;
    end else begin
      busy_run  = 0;
      prev_done = 1'b0;
      hold_frec = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Presents digits with iStart for one edge and records the expectation.
  // The caller guarantees the DUT is idle at that edge.
  task automatic issue(input logic [3:0] um, c, d, u, output int n);
    @(negedge iClk);
    iUM = um; iC = c; iD = d; iU = u;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    n = cyc;
    iStart = 1'b0;
    if (ref_bad(um, c, d, u)) begin
      err_cyc_q.push_back(n);
    end else begin
      exp_q.push_back(W'(ref_val(um, c, d, u)));
      exp_cyc_q.push_back(n + LAT);
    end
  endtask

  // A start pulse sampled at edge n+k that the DUT must ignore (it is busy).
  task automatic ignored_pulse(input int n, input int k);
    @(negedge iClk);
    while (cyc < n + k - 1) @(negedge iClk);
    iUM = 4'd1; iC = 4'd1; iD = 4'd1; iU = 4'd1;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || err_cyc_q.size() != 0) && k < budget) begin
      @(negedge iClk);
      k++;
    end
    if (exp_q.size() != 0 || err_cyc_q.size() != 0) begin
      fail_event("wait_idle_timeout");
      exp_q.delete();
      exp_cyc_q.delete();
      err_cyc_q.delete();
    end
    @(negedge iClk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n, n2, k;
    logic [3:0] dg[4];

    // Reset and reset-state checks.
    #2 iRst_n = 1'b0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_frec", 32'(oFrec), 32'd0);
    check("rst_done", {31'd0, oDone}, 32'd0);
    check("rst_error", {31'd0, oError}, 32'd0);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    @(posedge iClk);
    #2 iRst_n = 1'b1;
    repeat (2) @(negedge iClk);

    // Zero, maximum, and a mid value.
    issue(4'd0, 4'd0, 4'd0, 4'd0, n);
    wait_idle(LAT + 10);
    issue(4'd9, 4'd9, 4'd9, 4'd9, n);
    wait_idle(LAT + 10);

    // 1234, then 0007 started in the oDone cycle.
    issue(4'd1, 4'd2, 4'd3, 4'd4, n);
    k = 0;
    @(negedge iClk);
    while (!oDone && k < LAT + 10) begin
      @(negedge iClk);
      k++;
    end
    if (!oDone) fail_event("b2b_first_done_timeout");
    iUM = 4'd0; iC = 4'd0; iD = 4'd0; iU = 4'd7;
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    n2 = cyc;
    iStart = 1'b0;
    exp_q.push_back(W'(7));
    exp_cyc_q.push_back(n2 + LAT);
    wait_idle(LAT + 10);

    // Bad hundreds digit: error pulse only, oFrec keeps 7.
    issue(4'd0, 4'hA, 4'd0, 4'd0, n);
    wait_idle(10);
    repeat (3) @(negedge iClk);

    // Starts while busy are ignored.
    issue(4'd5, 4'd0, 4'd0, 4'd0, n);
    ignored_pulse(n, 5);
    ignored_pulse(n, LAT - 8);
    wait_idle(LAT + 10);

    // Reset mid-conversion aborts.
    issue(4'd8, 4'd1, 4'd9, 4'd2, n);
    repeat (9) @(posedge iClk);
    #2 iRst_n = 1'b0;
    #1;
    check("abort_frec", 32'(oFrec), 32'd0);
    check("abort_done", {31'd0, oDone}, 32'd0);
    check("abort_error", {31'd0, oError}, 32'd0);
    check("abort_busy", {31'd0, oBusy}, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    err_cyc_q.delete();
    repeat (2) @(posedge iClk);
    #2 iRst_n = 1'b1;
    repeat (LAT + 5) @(negedge iClk);
    issue(4'd8, 4'd1, 4'd9, 4'd2, n);
    wait_idle(LAT + 10);

    // Randomized conversions, some with an out-of-range digit.
    for (int t = 0; t < 24; t++) begin
      for (int j = 0; j < 4; j++) dg[j] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) dg[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
      issue(dg[0], dg[1], dg[2], dg[3], n);
      wait_idle(LAT + 10);
      repeat ($urandom_range(0, 3)) @(negedge iClk);
    end

    repeat (3) @(negedge iClk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
